// File: rtl/rv32i_types.sv
// ============================================================================
// Package : rv32i_types
// Brief   : Shared RV32I types plus the load/store unit state and fault codes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } lsu_state_t;

    typedef enum logic [1:0] {
        F_OK       = 2'b00,
        F_MISALIGN = 2'b01,
        F_ILLEGAL  = 2'b10,
        F_TIMEOUT  = 2'b11
    } lsu_fault_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module  : lsu_align
// Brief   : Store lane formatting, fault classification and load extension.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
    import rv32i_types::*;
(
    input  logic [6:0]     opcode,
    input  logic [2:0]     funct3,
    input  logic [1:0]     offset,
    input  rv32i_word      wdata,
    input  logic [2:0]     ld_funct3,
    input  logic [1:0]     ld_offset,
    input  rv32i_word      rdata,
    output logic           is_store,
    output logic [1:0]     fault,
    output rv32i_word      mem_wdata,
    output rv32i_mem_wmask byte_enable,
    output rv32i_word      load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Illegal encodings are classified before alignment is considered.
    always_comb begin
        is_store    = (opcode == op_store);
        fault       = F_OK;
        mem_wdata   = wdata;
        byte_enable = 4'b1111;
        if (opcode == op_load) begin
            case (funct3)
                lw:       if (offset != 2'b00) fault = F_MISALIGN;
                lh, lhu:  if (offset[0])       fault = F_MISALIGN;
                lb, lbu:  fault = F_OK;
                default:  fault = F_ILLEGAL;
            endcase
        end else if (opcode == op_store) begin
            case (funct3)
                sb: begin
                    mem_wdata   = {4{wdata[7:0]}};
                    byte_enable = 4'b0001 << offset;
                end
                sh: begin
                    mem_wdata   = {2{wdata[15:0]}};
                    byte_enable = 4'b0011 << offset;
                    if (offset[0]) fault = F_MISALIGN;
                end
                sw:      if (offset != 2'b00) fault = F_MISALIGN;
                default: fault = F_ILLEGAL;
            endcase
        end else begin
            fault = F_ILLEGAL;
        end
    end

    always_comb begin
        case (ld_offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            lb:      load_data = {{24{w_byte[7]}}, w_byte};
            lbu:     load_data = {24'd0, w_byte};
            lh:      load_data = {{16{w_half[15]}}, w_half};
            lhu:     load_data = {16'd0, w_half};
            default: load_data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module  : mem_lsu
// Brief   : RV32I memory-stage load/store unit with response timeout.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lsu
    import rv32i_types::*;
#(
    parameter int unsigned RESP_TIMEOUT = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_fault,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    localparam logic [31:0] c_timeout = 32'(RESP_TIMEOUT);

    lsu_state_t     r_state;
    lsu_state_t     w_state_next;
    logic [2:0]     r_funct3;
    logic [1:0]     r_offset;
    logic           r_is_store;
    logic [4:0]     r_rd;
    logic [31:0]    r_cnt;
    rv32i_word      r_address;
    rv32i_word      r_wdata;
    rv32i_mem_wmask r_be;
    logic [4:0]     r_rsp_rd;
    rv32i_word      r_rsp_data;
    logic [1:0]     r_rsp_fault;

    logic           w_is_store;
    logic [1:0]     w_fault;
    rv32i_word      w_mem_wdata;
    rv32i_mem_wmask w_be;
    rv32i_word      w_load_data;
    logic           w_accept;
    logic           w_timeout;

    lsu_align u_align (
        .opcode      (req_opcode),
        .funct3      (req_funct3),
        .offset      (req_addr[1:0]),
        .wdata       (req_wdata),
        .ld_funct3   (r_funct3),
        .ld_offset   (r_offset),
        .rdata       (dmem_rdata),
        .is_store    (w_is_store),
        .fault       (w_fault),
        .mem_wdata   (w_mem_wdata),
        .byte_enable (w_be),
        .load_data   (w_load_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = req_valid && (r_state == IDLE);
        // r_cnt counts completed wait cycles, so the limit trips on the last one.
        w_timeout    = (c_timeout != 32'd0) && ((r_cnt + 32'd1) == c_timeout);
        case (r_state)
            IDLE:    if (req_valid) w_state_next = (w_fault == F_OK) ? ACCESS : DONE;
            ACCESS:  if (dmem_resp || w_timeout) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_funct3    <= 3'd0;
            r_offset    <= 2'd0;
            r_is_store  <= 1'b0;
            r_rd        <= 5'd0;
            r_cnt       <= 32'd0;
            r_address   <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_rsp_rd    <= 5'd0;
            r_rsp_data  <= 32'd0;
            r_rsp_fault <= F_OK;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_funct3   <= req_funct3;
                r_offset   <= req_addr[1:0];
                r_is_store <= w_is_store;
                r_rd       <= req_rd;
                r_cnt      <= 32'd0;
                r_address  <= {req_addr[31:2], 2'b00};
                r_wdata    <= w_mem_wdata;
                r_be       <= w_be;
                if (w_fault != F_OK) begin
                    r_rsp_rd    <= req_rd;
                    r_rsp_data  <= 32'd0;
                    r_rsp_fault <= w_fault;
                end
            end
            // A response in the final wait cycle wins over the timeout.
            if (r_state == ACCESS) begin
                if (dmem_resp) begin
                    r_rsp_rd    <= r_rd;
                    r_rsp_data  <= r_is_store ? 32'd0 : w_load_data;
                    r_rsp_fault <= F_OK;
                end else if (w_timeout) begin
                    r_rsp_rd    <= r_rd;
                    r_rsp_data  <= 32'd0;
                    r_rsp_fault <= F_TIMEOUT;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

    assign req_ready        = (r_state == IDLE);
    assign rsp_valid        = (r_state == DONE);
    assign rsp_rd           = r_rsp_rd;
    assign rsp_data         = r_rsp_data;
    assign rsp_fault        = r_rsp_fault;
    assign dmem_read        = (r_state == ACCESS) && !r_is_store;
    assign dmem_write       = (r_state == ACCESS) && r_is_store;
    assign dmem_address     = r_address;
    assign dmem_wdata       = r_wdata;
    assign dmem_byte_enable = r_be;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module  : tb_mem_lsu
// Brief   : Self-checking bench for mem_lsu (vector table, corner sequences,
//           randomized traffic against a behavioural model).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    mem_lsu #(.RESP_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_opcode       (req_opcode),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .rsp_valid        (rsp_valid),
        .rsp_rd           (rsp_rd),
        .rsp_data         (rsp_data),
        .rsp_fault        (rsp_fault),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [1:0]  fault;
        logic [3:0]  be;
        logic [31:0] mw;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: access size/sign from funct3, faults from legality and size alignment.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, output logic [1:0] fault,
                                  output logic [3:0] be, output logic [31:0] mw,
                                  output logic [31:0] data);
        int size = 4;
        bit sgn = 0;
        bit legal = 0;
        int off;
        logic [31:0] mask;
        logic [31:0] val;
        if (op == 7'h03) begin
            legal = 1;
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: legal = 0;
            endcase
        end else if (op == 7'h23) begin
            legal = 1;
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: legal = 0;
            endcase
        end
        off   = int'(addr[1:0]);
        fault = !legal ? 2'd2 : ((off % size) != 0) ? 2'd1 : 2'd0;
        be    = 4'hF;
        mw    = wdata;
        data  = 32'd0;
        if (op == 7'h23 && fault == 2'd0) begin
            be = 4'(((1 << size) - 1) << off);
            if (size == 1)      mw = {24'd0, wdata[7:0]} * 32'h01010101;
            else if (size == 2) mw = {16'd0, wdata[15:0]} * 32'h00010001;
        end
        if (op == 7'h03 && fault == 2'd0) begin
            mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
            val  = (rdata >> (8 * off)) & mask;
            if (sgn && size < 4 && val[8 * size - 1]) val = val | ~mask;
            data = val;
        end
    endfunction

    task automatic do_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                          input int delay, input logic [1:0] fault, input logic [3:0] be,
                          input logic [31:0] mw, input logic [31:0] data, input string tag);
        int guard = 0;
        bit st = (op == 7'h23);
        while (!req_ready && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_opcode = op;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_opcode = 7'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
        if (fault != 2'd0) begin
            chk({tag, "/f_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "/f_fault"}, 32'(rsp_fault), 32'(fault));
            chk({tag, "/f_data"}, rsp_data, 32'd0);
            chk({tag, "/f_rd"}, 32'(rsp_rd), 32'(rd));
            chk({tag, "/f_strobe"}, 32'({dmem_read, dmem_write}), 32'd0);
            @(posedge clk); #1;
            chk({tag, "/f_valid_end"}, 32'(rsp_valid), 32'd0);
            chk({tag, "/f_strobe_end"}, 32'({dmem_read, dmem_write}), 32'd0);
        end else begin
            for (int i = 0; i <= delay; i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                end
                chk({tag, "/strobe"}, 32'({dmem_read, dmem_write}), st ? 32'd1 : 32'd2);
                chk({tag, "/addr"}, dmem_address, {addr[31:2], 2'b00});
                chk({tag, "/be"}, 32'(dmem_byte_enable), 32'(be));
                if (st) chk({tag, "/wdata"}, dmem_wdata, mw);
            end
            dmem_resp  = 1'b1;
            dmem_rdata = rdata;
            @(posedge clk); #1;
            dmem_resp  = 1'b0;
            dmem_rdata = $urandom;
            chk({tag, "/valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "/strobe_off"}, 32'({dmem_read, dmem_write}), 32'd0);
            chk({tag, "/data"}, rsp_data, data);
            chk({tag, "/fault"}, 32'(rsp_fault), 32'd0);
            chk({tag, "/rd"}, 32'(rsp_rd), 32'(rd));
            @(posedge clk); #1;
            chk({tag, "/valid_end"}, 32'(rsp_valid), 32'd0);
            chk({tag, "/ready_end"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        int reads;
        int guard;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata, mw, data;
        logic [1:0]  fault;
        logic [3:0]  be;

        tbl[0]  = '{7'h23, 3'd0, 32'h00001003, 32'h000000AB, 32'h0,        2, 2'd0, 4'b1000, 32'hABABABAB, 32'h0};
        tbl[1]  = '{7'h03, 3'd1, 32'h00002002, 32'h0,        32'h80011234, 0, 2'd0, 4'hF,    32'h0,        32'hFFFF8001};
        tbl[2]  = '{7'h03, 3'd5, 32'h00002002, 32'h0,        32'h80011234, 1, 2'd0, 4'hF,    32'h0,        32'h00008001};
        tbl[3]  = '{7'h03, 3'd0, 32'h00002001, 32'h0,        32'h80011234, 0, 2'd0, 4'hF,    32'h0,        32'h00000012};
        tbl[4]  = '{7'h03, 3'd2, 32'h00003002, 32'h0,        32'h0,        0, 2'd1, 4'hF,    32'h0,        32'h0};
        tbl[5]  = '{7'h03, 3'd3, 32'h00003000, 32'h0,        32'h0,        0, 2'd2, 4'hF,    32'h0,        32'h0};
        tbl[6]  = '{7'h23, 3'd2, 32'h00004000, 32'hDEADBEEF, 32'h0,        3, 2'd0, 4'hF,    32'hDEADBEEF, 32'h0};
        tbl[7]  = '{7'h23, 3'd1, 32'h00004002, 32'h1234CAFE, 32'h0,        1, 2'd0, 4'b1100, 32'hCAFECAFE, 32'h0};
        tbl[8]  = '{7'h03, 3'd4, 32'h00005003, 32'h0,        32'h9A000000, 0, 2'd0, 4'hF,    32'h0,        32'h0000009A};
        tbl[9]  = '{7'h03, 3'd0, 32'h00005003, 32'h0,        32'h9A000000, 2, 2'd0, 4'hF,    32'h0,        32'hFFFFFF9A};
        tbl[10] = '{7'h33, 3'd0, 32'h00005000, 32'h0,        32'h0,        0, 2'd2, 4'hF,    32'h0,        32'h0};
        tbl[11] = '{7'h23, 3'd4, 32'h00005000, 32'h0,        32'h0,        0, 2'd2, 4'hF,    32'h0,        32'h0};
        tbl[12] = '{7'h23, 3'd1, 32'h00004001, 32'h0,        32'h0,        0, 2'd1, 4'hF,    32'h0,        32'h0};
        tbl[13] = '{7'h03, 3'd2, 32'h00006000, 32'h0,        32'h12345678, 1, 2'd0, 4'hF,    32'h0,        32'h12345678};
        tbl[14] = '{7'h03, 3'd1, 32'h00006000, 32'h0,        32'h0000F00D, 0, 2'd0, 4'hF,    32'h0,        32'hFFFFF00D};
        tbl[15] = '{7'h03, 3'd7, 32'h00003003, 32'h0,        32'h0,        0, 2'd2, 4'hF,    32'h0,        32'h0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_opcode = 7'd0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        dmem_rdata = 32'd0;
        dmem_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/req_ready", 32'(req_ready), 32'd1);
        chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset/rsp_rd", 32'(rsp_rd), 32'd0);
        chk("reset/rsp_data", rsp_data, 32'd0);
        chk("reset/rsp_fault", 32'(rsp_fault), 32'd0);
        chk("reset/strobes", 32'({dmem_read, dmem_write}), 32'd0);
        chk("reset/address", dmem_address, 32'd0);
        chk("reset/wdata", dmem_wdata, 32'd0);
        chk("reset/be", 32'(dmem_byte_enable), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_txn(tbl[i].op, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, 5'(i + 1),
                   tbl[i].delay, tbl[i].fault, tbl[i].be, tbl[i].mw, tbl[i].data,
                   $sformatf("tbl%0d", i));
        end

        // Timeout: no response ever arrives.
        req_valid = 1'b1; req_opcode = 7'h03; req_funct3 = 3'd2; req_addr = 32'h7000; req_rd = 5'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reads = 0;
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            if (dmem_read) reads++;
            @(posedge clk); #1;
            guard++;
        end
        chk("timeout/read_cycles", 32'(reads), 32'd4);
        chk("timeout/valid", 32'(rsp_valid), 32'd1);
        chk("timeout/fault", 32'(rsp_fault), 32'd3);
        chk("timeout/data", rsp_data, 32'd0);
        chk("timeout/rd", 32'(rsp_rd), 32'd9);
        chk("timeout/strobe", 32'({dmem_read, dmem_write}), 32'd0);
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("stray/valid", 32'(rsp_valid), 32'd0);
        chk("stray/fault_held", 32'(rsp_fault), 32'd3);
        chk("stray/strobe", 32'({dmem_read, dmem_write}), 32'd0);
        @(posedge clk); #1;
        chk("stray/valid2", 32'(rsp_valid), 32'd0);
        chk("stray/ready", 32'(req_ready), 32'd1);

        // Reset in the middle of a store, followed by a late response.
        req_valid = 1'b1; req_opcode = 7'h23; req_funct3 = 3'd2; req_addr = 32'h8000;
        req_wdata = 32'h11223344; req_rd = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid/write", 32'(dmem_write), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; dmem_resp = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid/strobes", 32'({dmem_read, dmem_write}), 32'd0);
        chk("rst_mid/valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid/ready", 32'(req_ready), 32'd1);
        chk("rst_mid/address", dmem_address, 32'd0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("rst_late/valid", 32'(rsp_valid), 32'd0);
        chk("rst_late/strobes", 32'({dmem_read, dmem_write}), 32'd0);
        @(posedge clk); #1;
        chk("rst_late/valid2", 32'(rsp_valid), 32'd0);

        // Back-to-back with req_valid held high; second request must wait for DONE.
        req_valid = 1'b1; req_opcode = 7'h23; req_funct3 = 3'd2; req_addr = 32'h9004;
        req_wdata = 32'hA5A50001; req_rd = 5'd3;
        @(posedge clk); #1;
        req_opcode = 7'h03; req_funct3 = 3'd2; req_addr = 32'hA008; req_wdata = 32'h0; req_rd = 5'd4;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            chk("b2b/write", 32'(dmem_write), 32'd1);
            chk("b2b/addr", dmem_address, 32'h9004);
            chk("b2b/wdata", dmem_wdata, 32'hA5A50001);
            chk("b2b/be", 32'(dmem_byte_enable), 32'hF);
            chk("b2b/ready", 32'(req_ready), 32'd0);
        end
        dmem_resp = 1'b1;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("b2b/valid1", 32'(rsp_valid), 32'd1);
        chk("b2b/rd1", 32'(rsp_rd), 32'd3);
        chk("b2b/ready_done", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("b2b/ready_idle", 32'(req_ready), 32'd1);
        chk("b2b/no_read_yet", 32'(dmem_read), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b/read2", 32'(dmem_read), 32'd1);
        chk("b2b/addr2", dmem_address, 32'hA008);
        dmem_resp = 1'b1; dmem_rdata = 32'h13579BDF;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("b2b/valid2", 32'(rsp_valid), 32'd1);
        chk("b2b/data2", rsp_data, 32'h13579BDF);
        chk("b2b/rd2", 32'(rsp_rd), 32'd4);
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            int sel = $urandom_range(0, 15);
            op    = (sel < 7) ? 7'h03 : (sel < 14) ? 7'h23 : 7'($urandom);
            f3    = 3'($urandom_range(0, 7));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            model(op, f3, addr, wdata, rdata, fault, be, mw, data);
            do_txn(op, f3, addr, wdata, rdata, 5'($urandom), $urandom_range(0, 3),
                   fault, be, mw, data, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit of the RV32I pipeline.
- Accepts one load or store per request from the execute/memory pipeline register and issues a word-aligned read or write to the data memory port. Holds the request until the memory acknowledges.
- Returns load data extracted and sign/zero-extended for writeback, or reports a fault: misaligned access, illegal funct3, or response timeout.
- Pipeline stalls while req_ready is low.

Parameters:
- RESP_TIMEOUT, 0, cycles to wait for dmem_resp before faulting; 0 disables the timeout.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Synchronous, active-high reset.
- req_valid  input  1  Request present.
- req_ready  output  1  Unit can accept a request (high only in IDLE).
- req_opcode  input  7  rv32i_opcode; only op_load and op_store are legal.
- req_funct3  input  3  load_funct3_t or store_funct3_t.
- req_addr  input  32  Byte address (ALU result).
- req_wdata  input  32  Store data (rs2).
- req_rd  input  5  Destination register, carried through.
- rsp_valid  output  1  One-cycle completion pulse.
- rsp_rd  output  5  Destination register of the completed access.
- rsp_data  output  32  Extended load data; 0 for stores and faults.
- rsp_fault  output  2  00 ok, 01 misaligned, 10 illegal, 11 timeout.
- dmem_read  output  1  Read strobe.
- dmem_write  output  1  Write strobe.
- dmem_address  output  32  Word-aligned address {req_addr[31:2],2'b00}.
- dmem_wdata  output  32  Lane-replicated store data.
- dmem_byte_enable  output  4  rv32i_mem_wmask.
- dmem_rdata  input  32  Read data, valid with dmem_resp.
- dmem_resp  input  1  Access done.

Behaviour:
- Reset values:
  - state IDLE, req_ready 1.
  - rsp_valid 0, rsp_rd 0, rsp_data 0, rsp_fault 00.
  - dmem_read 0, dmem_write 0, dmem_address 0, dmem_wdata 0, dmem_byte_enable 0.
  - Timeout counter 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when req_valid && req_ready. Register opcode, funct3, addr, wdata, rd, computed byte offset, mask and fault.
  - If no fault, go to ACCESS; otherwise go to DONE with the fault code and no dmem strobe ever asserted.
- Fault classification, highest priority first:
  - Opcode not load/store, or funct3 outside the enum: illegal.
  - lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]=1: misaligned.
- ACCESS:
  - Exactly one of dmem_read/dmem_write is high. Address, wdata and byte_enable are stable from the first ACCESS cycle until the cycle dmem_resp is sampled high.
  - On dmem_resp: drop strobes next cycle, capture dmem_rdata, go to DONE.
  - If RESP_TIMEOUT>0 and the counter reaches RESP_TIMEOUT without resp: drop strobes, fault 11, go to DONE.
  - The counter clears on entry to ACCESS.
- DONE:
  - rsp_valid=1 for exactly one cycle with rsp_rd, rsp_data and rsp_fault, then return to IDLE.
  - Outputs hold their values until the next DONE.
- Latency: accept at cycle N, strobe visible from N+1. dmem_resp at cycle M (M≥N+1) gives rsp_valid at M+1. A fault at accept gives rsp_valid at N+1. Minimum request-to-request spacing is 3 cycles.
- Store formatting, with off=addr[1:0]:
  - sb: wdata={4{wdata[7:0]}}, be=4'b0001<<off.
  - sh: wdata={2{wdata[15:0]}}, be=4'b0011<<off.
  - sw: wdata passed through, be=1111.
- Loads: dmem_byte_enable=1111.
  - lb/lbu: select byte rdata[8*off+:8], then sign- or zero-extend.
  - lh/lhu: select rdata[16*off[1]+:16], then sign- or zero-extend.
  - lw: pass rdata through.
- Stray dmem_resp while in IDLE or DONE is ignored.
- rst in any state (including mid-ACCESS) forces reset values on the next edge. The pending access is abandoned with no rsp_valid; a late dmem_resp after reset is ignored.
- Request inputs are don't-care unless req_valid && req_ready.

Decomposition:
- Package rv32i_types: reuse rv32i_opcode, load_funct3_t, store_funct3_t, rv32i_word, rv32i_mem_wmask.
- Add to rv32i_types:
  - lsu_state_t enum {IDLE, ACCESS, DONE}.
  - lsu_fault_t enum {F_OK=2'b00, F_MISALIGN, F_ILLEGAL, F_TIMEOUT}.
- One combinational sub-module lsu_align: store mask/replication, fault classification, and load extraction/extension. mem_lsu holds the FSM, capture registers and timeout counter.

Test Plan:
- sb, addr 0x1003, wdata 0xAB, resp after 2 cycles -> address 0x1000, be 1000, wdata 0xABABABAB; rsp_valid one cycle after resp; fault 00, rsp_data 0.
- lh at 0x2002, rdata 0x8001_1234 -> rsp_data 0xFFFF8001; lhu at 0x2002 -> 0x00008001; lb at 0x2001 -> 0x00000012.
- lw at 0x3002 -> no strobe ever; rsp_valid at N+1, fault 01. Illegal funct3 011 on a load -> fault 10.
- RESP_TIMEOUT=4, dmem_resp never asserted -> dmem_read high exactly 4 cycles, then fault 11; a later dmem_resp is ignored.
- rst asserted on the 2nd ACCESS cycle of an sw, followed by dmem_resp -> strobes 0 the next cycle, no rsp_valid, req_ready 1.
- Back-to-back requests with req_valid held high -> second accepted only after DONE; address/wdata/be held stable across 3 wait cycles.
